win_unchange_checker: RTL and testbench
=======================================

Name: win_unchange_checker

Overview:
- Synthesizable-style window assertion checker.
- Once `start_event` opens a window, `test_expr` must hold its value at every sampled edge until `end_event` closes the window.
- Flags violations on `fire[0]`, X/Z problems on `fire[1]` and coverage on `fire[2]`.
- Bound alongside a DUT in verification benches; passive, drives nothing but `fire`.

Parameters:
- `width`, 4, bit width of `test_expr`.
- `MSG_EN`, 1, when 1 the checker prints a `$error` text on each violation (simulation only).

Ports:
- `clock`  input  1  sampling clock; all sampling on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `enable`  input  1  checker enable; 0 suspends checking.
- `start_event`  input  1  opens the window.
- `test_expr`  input  `width`  value that must stay unchanged inside the window.
- `end_event`  input  1  closes the window.
- `fire`  output  3  bit 0 = assertion failure, bit 1 = X/Z check failure, bit 2 = window-closed coverage.

Behaviour:
- Reset: while `reset`=0, the FSM is IDLE, `fire`=3'b000 and the stored value is 0. Reset is asynchronous assert, synchronous release.
- FSM states:
  - IDLE: at a rising edge with `enable`=1, `start_event`=1 and `end_event`=0, capture `test_expr` into `held` and go to OPEN.
  - IDLE, `start_event`=1 with `end_event`=1 in the same cycle: the window is empty. Stay IDLE, no check.
  - OPEN: each rising edge compares `test_expr` with `held`.
  - OPEN, mismatch: `fire[0]`=1 for exactly that cycle (registered, visible after the edge) and `held` updates to the new value, so one change gives one pulse.
  - OPEN, `end_event`=1: the comparison is still performed at that edge, then the FSM goes to IDLE and `fire[2]` pulses for one cycle.
- `start_event` while OPEN is ignored; the window does not restart and `held` is unchanged.
- Changes of `test_expr` in IDLE never fire.
- `enable`=0: FSM forced to IDLE at the next edge, `fire` forced to 0, no checks.
- Latency: `fire` bits are registered and assert one cycle after the offending sample edge. All `fire` bits are single-cycle pulses.
- `MSG_EN`=1: print time, instance path and the old/new values on every `fire[0]`.

Optional Feature:
- Macro: `WIN_UNCHANGE_XCHECK_EN`.
- Defined: at each edge with `enable`=1, `fire[1]` pulses if `start_event` or `end_event` is X/Z.
- Defined: `fire[1]` also pulses if `test_expr` has an X/Z bit while the FSM is OPEN.
- Defined: X/Z on `test_expr` in IDLE is ignored, so it is legal before the first window.
- Not defined: `fire[1]` is tied to 0 and no X/Z logic is compiled.

Decomposition:
- Shared package `win_unchange_pkg`:
  - FSM state enum `win_state_e` {IDLE, OPEN}.
  - Fire-bit index constants `FIRE_ASSERT`=0, `FIRE_XCHECK`=1, `FIRE_COVER`=2.
  - `FIRE_WIDTH`=3.
- One sub-module is natural: `win_unchange_xcheck`, the X/Z detector instantiated under the macro.
- The FSM and comparator stay in the top module.

Test Plan:
- Hold `reset`=0 for 5 clocks with `test_expr`=X and the events at 0 -> `fire`=000 throughout.
- `start_event`=1, `test_expr`=4'b1100 for 10 clocks, then `end_event`=1 -> `fire[0]` never asserts; `fire[2]` pulses once on close.
- Open with 4'b0011, change to 4'b0111 on the third clock, close 2 clocks later -> exactly one `fire[0]` pulse, one cycle after the change edge.
- `start_event` and `end_event` high together for 5 clocks, then `test_expr` 4'b1100->4'b0000 with both events low -> no `fire[0]`, because no window was ever open.
- Open window, change `test_expr` in the same cycle `end_event`=1 -> `fire[0]` and `fire[2]` both pulse; a later change in IDLE does not fire.
- Open window, drop `enable` to 0, change data, restore `enable` -> no fire and the FSM is IDLE. With `WIN_UNCHANGE_XCHECK_EN`, `test_expr`=4'bx010 inside an open window -> `fire[1]` pulses.

Source files
------------

// File: rtl/win_unchange_pkg.sv
// ---------------------------------------------------------------------------
// win_unchange_pkg
// Shared definitions for the window-unchange checker: the FSM state type and
// the bit positions inside the 3-bit `fire` output vector.
// No ports (package).
// ---------------------------------------------------------------------------
package win_unchange_pkg;

  // Window FSM: IDLE waits for a start, OPEN compares every sampled edge
  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } win_state_e;

  // Bit positions inside `fire`
  localparam int FIRE_ASSERT = 0;
  localparam int FIRE_XCHECK = 1;
  localparam int FIRE_COVER  = 2;
  localparam int FIRE_WIDTH  = 3;

endpackage

// File: rtl/win_unchange_xcheck.sv
// ---------------------------------------------------------------------------
// win_unchange_xcheck
// Combinational X/Z detector for the window-unchange checker. Only compiled
// into the top when WIN_UNCHANGE_XCHECK_EN is defined.
//
// Ports:
//   enable       in   checker enable; no flag while low
//   window_open  in   FSM is OPEN; test_expr is only screened while open
//   start_event  in   window open event, screened at every enabled edge
//   end_event    in   window close event, screened at every enabled edge
//   test_expr    in   [width] watched value
//   xz_flag      out  1 when an X/Z is seen on a screened input
// ---------------------------------------------------------------------------
module win_unchange_xcheck #(
  parameter int width = 4
) (
  input  logic             enable,
  input  logic             window_open,
  input  logic             start_event,
  input  logic             end_event,
  input  logic [width-1:0] test_expr,
  output logic             xz_flag
);

  // X/Z on test_expr before the first window is legal, so the data screen
  // is qualified by window_open while the events are always screened.
  always_comb begin
    xz_flag = 1'b0;
    if (enable) begin
      xz_flag = $isunknown(start_event) || $isunknown(end_event) ||
                (window_open && $isunknown(test_expr));
    end
  end

endmodule

// File: rtl/win_unchange_checker.sv
// ---------------------------------------------------------------------------
// win_unchange_checker
// Passive window assertion checker. Once start_event opens a window,
// test_expr must keep its value at every rising clock edge until end_event
// closes the window. All fire bits are registered single-cycle pulses that
// appear one cycle after the offending sample edge.
//
// Optional feature: define WIN_UNCHANGE_XCHECK_EN to compile the X/Z
// detector that drives fire[1]; otherwise fire[1] is tied to 0.
//
// Parameters:
//   width   bit width of test_expr
//   MSG_EN  1 prints a simulation-only $error on every fire[0]
//
// Ports:
//   clock        in   sampling clock, rising edge
//   reset        in   asynchronous active-low reset
//   enable       in   checker enable; 0 suspends checking and forces IDLE
//   start_event  in   opens the window
//   test_expr    in   [width] value that must stay unchanged in the window
//   end_event    in   closes the window
//   fire         out  [3] bit0 assertion, bit1 X/Z check, bit2 close cover
// ---------------------------------------------------------------------------
module win_unchange_checker
  import win_unchange_pkg::*;
#(
  parameter int width  = 4,
  parameter bit MSG_EN = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start_event,
  input  logic [width-1:0]      test_expr,
  input  logic                  end_event,
  output logic [FIRE_WIDTH-1:0] fire
);

  win_state_e       state;
  logic [width-1:0] held;
  logic             fire_assert;
  logic             fire_cover;
  logic             fire_xcheck;

  // Window FSM and comparator. On a mismatch the held value follows the new
  // value so a single change yields a single pulse. The close edge still
  // performs its comparison before returning to IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      held        <= '0;
      fire_assert <= 1'b0;
      fire_cover  <= 1'b0;
    end else if (!enable) begin
      state       <= IDLE;
      fire_assert <= 1'b0;
      fire_cover  <= 1'b0;
    end else begin
      fire_assert <= 1'b0;
      fire_cover  <= 1'b0;
      case (state)
        IDLE: begin
          // start and end together describe an empty window: nothing to do
          if (start_event && !end_event) begin
            held  <= test_expr;
            state <= OPEN;
          end
        end
        OPEN: begin
          if (test_expr != held) begin
            fire_assert <= 1'b1;
            held        <= test_expr;
          end
          if (end_event) begin
            state      <= IDLE;
            fire_cover <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WIN_UNCHANGE_XCHECK_EN
  logic xz_flag;

  win_unchange_xcheck #(
    .width(width)
  ) u_xcheck (
    .enable     (enable),
    .window_open(state == OPEN),
    .start_event(start_event),
    .end_event  (end_event),
    .test_expr  (test_expr),
    .xz_flag    (xz_flag)
  );

  // Register the X/Z flag so fire[1] has the same latency as the other bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fire_xcheck <= 1'b0;
    end else begin
      fire_xcheck <= xz_flag;
    end
  end
`else
  assign fire_xcheck = 1'b0;
`endif

`ifndef SYNTHESIS
  // Simulation-only violation message, mirroring the fire[0] condition
  always @(posedge clock) begin
    if (MSG_EN && reset && enable && state == OPEN && test_expr != held) begin
      $error("%t %m: test_expr changed inside window, old=%h new=%h",
             $time, held, test_expr);
    end
  end
`endif

  // Pack the individual pulses into the fire vector
  always_comb begin
    fire              = '0;
    fire[FIRE_ASSERT] = fire_assert;
    fire[FIRE_XCHECK] = fire_xcheck;
    fire[FIRE_COVER]  = fire_cover;
  end

endmodule

// File: tb/tb_win_unchange_checker.sv
// ---------------------------------------------------------------------------
// tb_win_unchange_checker
// Self-checking bench for win_unchange_checker. Directed vectors with
// hand-computed fire values are applied from a table; multi-cycle corner
// cases (reset, async reset inside a window, X/Z screening) are written out.
// Each vector is driven on the falling edge and fire is sampled 1 time unit
// after the following rising edge, so the expected value belongs to that edge.
// ---------------------------------------------------------------------------
module tb_win_unchange_checker;

  typedef struct {
    logic       en;
    logic       st;
    logic       ed;
    logic [3:0] te;
    logic [2:0] exp_fire;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       start_event;
  logic [3:0] test_expr;
  logic       end_event;
  logic [2:0] fire;

  int checks;
  int errors;
  vec_t vecs[$];

  win_unchange_checker #(
    .width (4),
    .MSG_EN(1'b0)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .enable     (enable),
    .start_event(start_event),
    .test_expr  (test_expr),
    .end_event  (end_event),
    .fire       (fire)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Add one table entry
  function automatic void add_vec(input logic en, input logic st,
                                  input logic ed, input logic [3:0] te,
                                  input logic [2:0] exp_fire);
    vec_t v;
    v.en = en;
    v.st = st;
    v.ed = ed;
    v.te = te;
    v.exp_fire = exp_fire;
    vecs.push_back(v);
  endfunction

  // Drive inputs on the falling edge, then move past the next rising edge
  task automatic apply_stimulus(input logic en, input logic st,
                                input logic ed, input logic [3:0] te);
    @(negedge clk);
    enable      = en;
    start_event = st;
    end_event   = ed;
    test_expr   = te;
    @(posedge clk);
    #1;
  endtask

  // Compare fire with the expected value
  task automatic check_output(input string name, input logic [2:0] exp_fire);
    checks++;
    if (fire !== exp_fire) begin
      errors++;
      $display("[TB] FAIL %s: fire=%b expected=%b at %0t", name, fire,
               exp_fire, $time);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    enable      = 1'b1;
    start_event = 1'b0;
    end_event   = 1'b0;
    test_expr   = 4'bxxxx;

    // Reset held for 5 clocks with unknown data: fire stays quiet
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("reset_%0d", i), 3'b000);
    end
    @(negedge clk);
    reset     = 1'b1;
    test_expr = 4'b0000;

    // Stable window of 1100 with start held high, then close
    add_vec(1, 1, 0, 4'b1100, 3'b000);
    for (int i = 0; i < 9; i++) add_vec(1, 1, 0, 4'b1100, 3'b000);
    add_vec(1, 0, 1, 4'b1100, 3'b100);
    add_vec(1, 0, 0, 4'b1100, 3'b000);
    // Open with 0011, change to 0111 on the third clock, close 2 later
    add_vec(1, 1, 0, 4'b0011, 3'b000);
    add_vec(1, 0, 0, 4'b0011, 3'b000);
    add_vec(1, 0, 0, 4'b0111, 3'b001);
    add_vec(1, 0, 0, 4'b0111, 3'b000);
    add_vec(1, 0, 1, 4'b0111, 3'b100);
    add_vec(1, 0, 0, 4'b0111, 3'b000);
    // Empty windows: start and end together, then data changes in IDLE
    for (int i = 0; i < 5; i++) add_vec(1, 1, 1, 4'b1100, 3'b000);
    add_vec(1, 0, 0, 4'b0000, 3'b000);
    add_vec(1, 0, 0, 4'b0000, 3'b000);
    // Change on the closing edge fires both, later IDLE change is silent
    add_vec(1, 1, 0, 4'b0101, 3'b000);
    add_vec(1, 0, 0, 4'b0101, 3'b000);
    add_vec(1, 0, 1, 4'b1010, 3'b101);
    add_vec(1, 0, 0, 4'b1111, 3'b000);
    add_vec(1, 0, 0, 4'b0000, 3'b000);
    // Disable inside a window: forced to IDLE, no checks after re-enable
    add_vec(1, 1, 0, 4'b1001, 3'b000);
    add_vec(0, 0, 0, 4'b1001, 3'b000);
    add_vec(0, 0, 0, 4'b0110, 3'b000);
    add_vec(1, 0, 0, 4'b0110, 3'b000);
    add_vec(1, 0, 0, 4'b0001, 3'b000);
    add_vec(1, 0, 1, 4'b0001, 3'b000);
    // Start while open is ignored: held keeps the first captured value
    add_vec(1, 1, 0, 4'b0010, 3'b000);
    add_vec(1, 1, 0, 4'b0010, 3'b000);
    add_vec(1, 1, 0, 4'b0100, 3'b001);
    add_vec(1, 1, 0, 4'b0100, 3'b000);
    add_vec(1, 0, 1, 4'b0100, 3'b100);
    add_vec(1, 0, 0, 4'b0100, 3'b000);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].en, vecs[i].st, vecs[i].ed, vecs[i].te);
      check_output($sformatf("vec_%0d", i), vecs[i].exp_fire);
    end

    // Async reset inside a window clears a pending pulse immediately
    apply_stimulus(1, 1, 0, 4'b0011);
    check_output("arst_open", 3'b000);
    apply_stimulus(1, 0, 0, 4'b1000);
    check_output("arst_pulse", 3'b001);
    #2;
    reset = 1'b0;
    #1;
    check_output("arst_clear", 3'b000);
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(1, 0, 0, 4'b0001);
    check_output("arst_idle_change", 3'b000);
    apply_stimulus(1, 0, 1, 4'b0001);
    check_output("arst_idle_end", 3'b000);

`ifdef WIN_UNCHANGE_XCHECK_EN
    // X/Z on data inside an open window raises fire[1]
    apply_stimulus(1, 1, 0, 4'b0010);
    check_output("xz_open", 3'b000);
    apply_stimulus(1, 0, 0, 4'bx010);
    checks++;
    if (fire[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL xz_data: fire[1]=%b expected=1", fire[1]);
    end
    apply_stimulus(1, 0, 1, 4'b0010);
    apply_stimulus(1, 0, 0, 4'b0010);
    check_output("xz_after", 3'b000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time=%0t expected=finish before 100000",
             $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
